// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: owns the program counter, fetches over a req/ack
// port, presents the instruction to the datapath, and picks the next PC on commit.
module pc_sequencer #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR = WIDTH'(32'h0000_0100)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             boot_en,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [WIDTH-1:0] pc,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             commit,
  input  logic             stall,
  input  logic             redirect,
  input  logic             is_jalr,
  input  logic [WIDTH-1:0] target,
  output logic             trap_valid,
  output logic [WIDTH-1:0] trap_epc,
  output logic [WIDTH-1:0] trap_tval,
  output logic [WIDTH-1:0] retire_count,
  output logic [1:0]       state_dbg
);

  // Handshakes: imem_req stays high until the cycle imem_ack is seen in FETCH;
  // instr_valid stays high until the datapath commits with stall low.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    TRAP  = 2'd3
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t           state;
  logic [WIDTH-1:0] nxt;
  logic             misaligned;

  always_comb begin
    nxt = pc + WIDTH'(4);
    if (redirect) begin
      nxt = is_jalr ? {target[WIDTH-1:1], 1'b0} : target;
    end
    misaligned = |nxt[1:0];
  end

  assign imem_addr = pc;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      imem_req     <= 1'b0;
      instr        <= NOP;
      instr_valid  <= 1'b0;
      trap_valid   <= 1'b0;
      trap_epc     <= '0;
      trap_tval    <= '0;
      retire_count <= '0;
    end else begin
      trap_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (boot_en) begin
            imem_req <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (commit && !stall) begin
            instr_valid <= 1'b0;
            if (misaligned) begin
              // A misaligned target does not retire the instruction.
              trap_epc   <= pc;
              trap_tval  <= nxt;
              trap_valid <= 1'b1;
              state      <= TRAP;
            end else begin
              pc           <= nxt;
              retire_count <= retire_count + WIDTH'(1);
              imem_req     <= 1'b1;
              state        <= FETCH;
            end
          end
        end
        TRAP: begin
          pc       <= TRAP_VECTOR;
          imem_req <= 1'b1;
          state    <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch addresses and traps are checked by
// monitors against expected queues; an 8-bit instance covers counter wrap.
module tb_pc_sequencer;

  localparam logic [31:0] TV  = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot_en, imem_req, imem_ack, instr_valid;
  logic        commit, stall, redirect, is_jalr, trap_valid;
  logic [31:0] imem_addr, imem_rdata, pc, instr, target;
  logic [31:0] trap_epc, trap_tval, retire_count;
  logic [1:0]  state_dbg;

  logic        s_boot, s_req, s_ack, s_valid, s_commit, s_trap;
  logic [7:0]  s_addr, s_pc, s_epc, s_tval, s_retire;
  logic [31:0] s_instr;
  logic [1:0]  s_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [63:0] trap_q[$];

  pc_sequencer dut (
    .clk(clk), .rst(rst), .boot_en(boot_en), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .instr(instr), .instr_valid(instr_valid), .commit(commit),
    .stall(stall), .redirect(redirect), .is_jalr(is_jalr), .target(target),
    .trap_valid(trap_valid), .trap_epc(trap_epc), .trap_tval(trap_tval),
    .retire_count(retire_count), .state_dbg(state_dbg)
  );

  pc_sequencer #(.WIDTH(8), .RESET_PC(8'h00), .TRAP_VECTOR(8'h40)) dut_small (
    .clk(clk), .rst(rst), .boot_en(s_boot), .imem_req(s_req),
    .imem_addr(s_addr), .imem_ack(s_ack), .imem_rdata(32'h0000_0013),
    .pc(s_pc), .instr(s_instr), .instr_valid(s_valid), .commit(s_commit),
    .stall(1'b0), .redirect(1'b0), .is_jalr(1'b0), .target(8'h00),
    .trap_valid(s_trap), .trap_epc(s_epc), .trap_tval(s_tval),
    .retire_count(s_retire), .state_dbg(s_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Monitors: a new fetch request pops the expected address; a trap pops epc/tval.
  logic req_prev = 1'b0;
  logic trap_prev = 1'b0;
  always @(negedge clk) begin
    if (imem_req && !req_prev) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL fetch_unexpected: got addr %h expected no fetch", imem_addr);
      end else begin
        check("fetch_addr", imem_addr, exp_q.pop_front());
      end
    end
    if (trap_valid) begin
      if (trap_prev) begin
        checks++; errors++;
        $display("FAIL trap_pulse: got trap_valid high 2 cycles expected 1");
      end else if (trap_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL trap_unexpected: got epc %h expected no trap", trap_epc);
      end else begin
        logic [63:0] t;
        t = trap_q.pop_front();
        check("trap_epc", trap_epc, t[63:32]);
        check("trap_tval", trap_tval, t[31:0]);
      end
    end
    req_prev  = imem_req;
    trap_prev = trap_valid;
  end

  // Drivers
  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check1("fetch_req", imem_req, 1'b1);
  endtask

  task automatic fetch(input int wait_n, input logic [31:0] data, input logic [31:0] exp_pc);
    wait_req();
    check("fetch_pc", pc, exp_pc);
    repeat (wait_n) begin
      @(posedge clk); #1;
      check1("wait_req_held", imem_req, 1'b1);
      check1("wait_valid_low", instr_valid, 1'b0);
      check("wait_pc_held", pc, exp_pc);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check1("exec_valid", instr_valid, 1'b1);
    check("exec_instr", instr, data);
    check1("exec_req_low", imem_req, 1'b0);
  endtask

  task automatic do_commit(input int stall_n, input logic rd, input logic jr,
                           input logic [31:0] tgt, input logic [31:0] cur_pc,
                           input logic [31:0] cur_instr, input logic [31:0] exp_next,
                           input logic exp_trap);
    repeat (stall_n) begin
      stall = 1'b1; commit = 1'b1; redirect = 1'b1; is_jalr = 1'b0; target = 32'h2;
      @(posedge clk); #1;
      check("stall_pc", pc, cur_pc);
      check("stall_instr", instr, cur_instr);
      check1("stall_valid", instr_valid, 1'b1);
      check1("stall_req", imem_req, 1'b0);
    end
    stall = 1'b0; commit = 1'b1; redirect = rd; is_jalr = jr; target = tgt;
    if (exp_trap) begin
      trap_q.push_back({cur_pc, exp_next});
      exp_q.push_back(TV);
    end else begin
      exp_q.push_back(exp_next);
    end
    @(posedge clk); #1;
    commit = 1'b0; redirect = 1'b0; is_jalr = 1'b0; target = $urandom;
    check1("commit_valid_low", instr_valid, 1'b0);
    if (!exp_trap) begin
      check1("commit_req", imem_req, 1'b1);
      check("commit_pc", pc, exp_next);
    end else begin
      check1("trap_valid_on", trap_valid, 1'b1);
      check1("trap_req_low", imem_req, 1'b0);
      @(posedge clk); #1;
      check1("trap_valid_off", trap_valid, 1'b0);
      check("trap_pc", pc, TV);
      check1("trap_req", imem_req, 1'b1);
    end
  endtask

  task automatic check_reset_values();
    check("rst_state", {30'b0, state_dbg}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check1("rst_req", imem_req, 1'b0);
    check("rst_instr", instr, NOP);
    check1("rst_valid", instr_valid, 1'b0);
    check1("rst_trap", trap_valid, 1'b0);
    check("rst_epc", trap_epc, 32'h0);
    check("rst_tval", trap_tval, 32'h0);
    check("rst_retire", retire_count, 32'h0);
  endtask

  // Stimulus
  initial begin
    rst = 1'b1; boot_en = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    commit = 1'b0; stall = 1'b0; redirect = 1'b0; is_jalr = 1'b0; target = '0;
    s_boot = 1'b0; s_ack = 1'b0; s_commit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_values();

    // boot and sequential fetch
    exp_q.push_back(32'h0);
    boot_en = 1'b1;
    @(posedge clk); #1;
    boot_en = 1'b0;
    check1("boot_req", imem_req, 1'b1);
    fetch(0, NOP, 32'h0);
    do_commit(0, 1'b0, 1'b0, 32'h0, 32'h0, NOP, 32'h4, 1'b0);
    fetch(0, NOP, 32'h4);
    do_commit(0, 1'b0, 1'b0, 32'h0, 32'h4, NOP, 32'h8, 1'b0);

    // branch and jalr
    fetch(0, 32'h0400_006F, 32'h8);
    do_commit(0, 1'b1, 1'b0, 32'h40, 32'h8, 32'h0400_006F, 32'h40, 1'b0);
    check("retire_3", retire_count, 32'd3);
    fetch(0, 32'h0000_80E7, 32'h40);
    do_commit(0, 1'b1, 1'b1, 32'h81, 32'h40, 32'h0000_80E7, 32'h80, 1'b0);
    fetch(0, NOP, 32'h80);
    do_commit(0, 1'b1, 1'b0, 32'h40, 32'h80, NOP, 32'h40, 1'b0);
    check("retire_5", retire_count, 32'd5);

    // misaligned trap
    fetch(0, 32'h0020_006F, 32'h40);
    do_commit(0, 1'b1, 1'b0, 32'h42, 32'h40, 32'h0020_006F, 32'h42, 1'b1);
    check("retire_after_trap", retire_count, 32'd5);
    check("epc_held", trap_epc, 32'h40);
    check("tval_held", trap_tval, 32'h42);

    // memory wait states and stall
    fetch(3, 32'hDEAD_BEEF, TV);
    do_commit(4, 1'b0, 1'b0, 32'h0, TV, 32'hDEAD_BEEF, 32'h104, 1'b0);
    check("retire_6", retire_count, 32'd6);

    // pc wrap-around
    fetch(0, NOP, 32'h104);
    do_commit(0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h104, NOP, 32'hFFFF_FFFC, 1'b0);
    fetch(1, NOP, 32'hFFFF_FFFC);
    do_commit(0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, NOP, 32'h0, 1'b0);
    check("retire_8", retire_count, 32'd8);

    // reset mid-fetch, then a late ack
    check1("pre_rst_req", imem_req, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_values();
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    repeat (3) begin
      @(posedge clk); #1;
      check1("late_ack_valid", instr_valid, 1'b0);
      check1("late_ack_req", imem_req, 1'b0);
      check("late_ack_state", {30'b0, state_dbg}, 32'd0);
      check("late_ack_instr", instr, NOP);
    end
    imem_ack = 1'b0;

    // retire counter wrap on the 8-bit instance
    s_boot = 1'b1;
    @(posedge clk); #1;
    s_boot = 1'b0;
    for (int i = 0; i < 256; i++) begin
      int n = 0;
      while (!s_req && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      if (!s_req) begin
        check1("small_req", s_req, 1'b1);
        break;
      end
      s_ack = 1'b1;
      @(posedge clk); #1;
      s_ack = 1'b0;
      s_commit = 1'b1;
      @(posedge clk); #1;
      s_commit = 1'b0;
      if (i == 254) check("small_retire_255", {24'b0, s_retire}, 32'd255);
    end
    check("small_retire_wrap", {24'b0, s_retire}, 32'd0);
    check("small_pc_wrap", {24'b0, s_pc}, 32'd0);

    repeat (2) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("trap_q_drained", trap_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
